// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Contents: state_e (IDLE/REQ/HOLD/KILL), NOP_INSTR (bubble encoding), PC_STEP (bytes per fetch).
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
// Signals: req/addr (fetch side to memory), ready/data (memory to fetch side).
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] data;
    modport master (output req, addr, input ready, data);
    modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/fetch_unit_hold_buf.sv
// fetch_hold_buf: one-entry {pc, instr} buffer that parks a fetched instruction during a stall.
// Ports: clk_i, rst_i (async active-low), load_i/pc_i/instr_i (capture), release_i (consumed),
//        discard_i (dropped by a redirect), pc_o/instr_o (buffered entry).
module fetch_hold_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        release_i,
    input  logic        discard_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [31:0] pc_q, instr_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (release_i || discard_i) begin
            pc_q    <= '0;
            instr_q <= '0;
        end
    end
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, fetching over a req/ready bus and feeding the IF/ID register.
// Ports: clk_i, rst_i (async active-low), flush_i/target_i (ID redirect), stall_i (ID hazard),
//        imem (fetch_unit_if.master), ifid_valid_o/ifid_pc_o/ifid_instr_o (IF/ID register).
// Optional: define FETCH_PERF_EN to add perf_fetch_o, perf_flush_o, perf_kill_o counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [31:0]        target_i,
    input  logic               stall_i,
    fetch_unit_if.master       imem,
    output logic               ifid_valid_o,
    output logic [31:0]        ifid_pc_o,
    output logic [31:0]        ifid_instr_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_flush_o,
    output logic [31:0]        perf_kill_o
`endif
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, redir_q, redir_d;
    logic        ifid_valid_q;
    logic [31:0] ifid_pc_q, ifid_instr_q;
    logic        deliver, buf_load, buf_release, buf_discard, kill;
    logic [31:0] dpc, dinstr, buf_pc, buf_instr;

    fetch_hold_buf u_hold (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (buf_load),
        .release_i (buf_release),
        .discard_i (buf_discard),
        .pc_i      (pc_q),
        .instr_i   (imem.data),
        .pc_o      (buf_pc),
        .instr_o   (buf_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        deliver     = 1'b0;
        dpc         = pc_q;
        dinstr      = imem.data;
        buf_load    = 1'b0;
        buf_release = 1'b0;
        buf_discard = 1'b0;
        kill        = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem.ready) begin
                    if (flush_i) begin
                        pc_d = target_i;
                        kill = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                        if (stall_i) begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    redir_d = target_i;
                    state_d = KILL;
                    kill    = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_d        = target_i;
                    buf_discard = 1'b1;
                    state_d     = REQ;
                end else if (!stall_i) begin
                    deliver     = 1'b1;
                    dpc         = buf_pc;
                    dinstr      = buf_instr;
                    buf_release = 1'b1;
                    state_d     = REQ;
                end
            end
            KILL: begin
                // A flush coinciding with the stale ready is the newest target, so it wins.
                if (flush_i) redir_d = target_i;
                if (imem.ready) begin
                    pc_d    = flush_i ? target_i : redir_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            redir_q      <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            if (flush_i) begin
                ifid_valid_q <= 1'b0;
                ifid_pc_q    <= '0;
                ifid_instr_q <= NOP_INSTR;
            end else if (!stall_i) begin
                ifid_valid_q <= deliver;
                ifid_pc_q    <= deliver ? dpc : '0;
                ifid_instr_q <= deliver ? dinstr : NOP_INSTR;
            end
        end
    end

    assign imem.req     = (state_q == REQ) || (state_q == KILL);
    assign imem.addr    = pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q, perf_kill_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(deliver);
            perf_flush_q <= perf_flush_q + 32'(flush_i);
            perf_kill_q  <= perf_kill_q + 32'(kill);
        end
    end
    assign perf_fetch_o = perf_fetch_q;
    assign perf_flush_o = perf_flush_q;
    assign perf_kill_o  = perf_kill_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a per-cycle reference model and literal checkpoints.
module tb_fetch_unit;
    localparam int P_IDLE = 0, P_REQ = 1, P_HOLD = 2, P_KILL = 3;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [31:0] target = '0;
    logic        ifid_v;
    logic [31:0] ifid_pc, ifid_ins;
    int          ws = 0, wcnt, checks = 0, failures = 0, cyc = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_flush, perf_kill;
`endif

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .flush_i      (flush),
        .target_i     (target),
        .stall_i      (stall),
        .imem         (bus),
        .ifid_valid_o (ifid_v),
        .ifid_pc_o    (ifid_pc),
        .ifid_instr_o (ifid_ins)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_flush_o (perf_flush),
        .perf_kill_o  (perf_kill)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: each request waits ws cycles before ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (bus.req && !bus.ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign bus.ready = bus.req && (wcnt >= ws);
    assign bus.data  = bus.ready ? memf(bus.addr) : 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Reference model, following the fetch rules transaction by transaction.
    int          m_st;
    logic        m_v, del;
    logic [31:0] m_pc, m_ipc, m_ins, m_bpc, m_bins, m_redir, dpc, dins;
    logic [31:0] m_fetch, m_flush, m_kill;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = P_IDLE; m_pc = 0; m_v = 0; m_ipc = 0; m_ins = 0;
            m_bpc = 0; m_bins = 0; m_redir = 0; m_fetch = 0; m_flush = 0; m_kill = 0;
        end else begin
            cyc++;
            del = 0; dpc = 0; dins = 0;
            if (flush) m_flush++;
            if (m_st == P_IDLE) m_st = P_REQ;
            else if (m_st == P_REQ) begin
                if (bus.ready && flush) begin m_pc = target; m_kill++; end
                else if (bus.ready && stall) begin
                    m_bpc = m_pc; m_bins = memf(m_pc); m_pc += 4; m_st = P_HOLD;
                end else if (bus.ready) begin
                    del = 1; dpc = m_pc; dins = memf(m_pc); m_pc += 4;
                end else if (flush) begin m_redir = target; m_st = P_KILL; m_kill++; end
            end else if (m_st == P_HOLD) begin
                if (flush) begin m_pc = target; m_st = P_REQ; end
                else if (!stall) begin del = 1; dpc = m_bpc; dins = m_bins; m_st = P_REQ; end
            end else begin
                if (flush) m_redir = target;
                if (bus.ready) begin m_pc = m_redir; m_st = P_REQ; end
            end
            if (flush) begin m_v = 0; m_ipc = 0; m_ins = 0; end
            else if (!stall) begin m_v = del; m_ipc = dpc; m_ins = dins; end
            if (del && !flush && !stall) m_fetch++;
        end
    end

    always @(negedge clk) begin
        chk("req", 32'(bus.req), 32'(m_st == P_REQ || m_st == P_KILL));
        chk("addr", bus.addr, m_pc);
        chk("ifid_valid", 32'(ifid_v), 32'(m_v));
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_instr", ifid_ins, m_ins);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_flush", perf_flush, m_flush);
        chk("perf_kill", perf_kill, m_kill);
`endif
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_req"}, 32'(bus.req), 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_valid"}, 32'(ifid_v), 0);
        chk({tag, "_pc"}, ifid_pc, 0);
        chk({tag, "_instr"}, ifid_ins, 0);
    endtask

    initial begin
        @(negedge clk);
        reset_vals("rst");
        #2 rst_n = 1'b1;
        // Zero-wait streaming from RESET_PC.
        @(negedge clk);
        chk("first_req", 32'(bus.req), 1);
        chk("first_addr", bus.addr, 32'h0);
        @(negedge clk);
        chk("s_addr4", bus.addr, 32'h4);
        chk("s_ifid_v0", 32'(ifid_v), 1);
        chk("s_ifid_pc0", ifid_pc, 32'h0);
        chk("s_ifid_ins0", ifid_ins, 32'h1357_9BDF);
        @(negedge clk);
        chk("s_addr8", bus.addr, 32'h8);
        chk("s_ifid_pc4", ifid_pc, 32'h4);
        // Two wait states; flush on the first wait cycle of address 8.
        ws = 2; flush = 1; target = 32'h40;
        @(negedge clk);
        flush = 0;
        chk("k_addr_stable", bus.addr, 32'h8);
        chk("k_req", 32'(bus.req), 1);
        chk("k_bubble", 32'(ifid_v), 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("k_target", bus.addr, 32'h40);
        chk("k_no_load", 32'(ifid_v), 0);
`ifdef FETCH_PERF_EN
        chk("k_perf_kill", perf_kill, 1);
`endif
        // Redirect to 0x10 with zero-wait memory, then stall 3 cycles over its ready.
        ws = 0; flush = 1; target = 32'h10;
        @(negedge clk);
        flush = 0;
        chk("r_addr10", bus.addr, 32'h10);
        stall = 1;
        @(negedge clk);
        chk("h_req_off", 32'(bus.req), 0);
        @(negedge clk);
        chk("h_req_off2", 32'(bus.req), 0);
        @(negedge clk);
        stall = 0;
        @(negedge clk);
        chk("h_valid", 32'(ifid_v), 1);
        chk("h_pc", ifid_pc, 32'h10);
        chk("h_instr", ifid_ins, memf(32'h10));
        chk("h_next", bus.addr, 32'h14);
        // Flush together with stall while in HOLD.
        stall = 1;
        @(negedge clk);
        flush = 1; target = 32'h80;
        @(negedge clk);
        flush = 0; stall = 0;
        chk("fh_bubble", 32'(ifid_v), 0);
        chk("fh_instr", ifid_ins, 0);
        chk("fh_addr", bus.addr, 32'h80);
        @(negedge clk);
        chk("fh_pc80", ifid_pc, 32'h80);
        chk("fh_addr84", bus.addr, 32'h84);
        // PC wrap-around.
        flush = 1; target = 32'hFFFF_FFFC;
        @(negedge clk);
        flush = 0;
        chk("w_top", bus.addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_wrap", bus.addr, 32'h0);
        chk("w_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        // Two flushes while in KILL: last target wins.
        ws = 2; flush = 1; target = 32'h100;
        @(negedge clk);
        target = 32'h200;
        @(negedge clk);
        flush = 0;
        @(negedge clk);
        chk("kk_target", bus.addr, 32'h200);
        chk("kk_req", 32'(bus.req), 1);
`ifdef FETCH_PERF_EN
        chk("kk_perf_flush", perf_flush, 6);
`endif
        // Reset asserted mid-KILL.
        flush = 1; target = 32'h300;
        @(negedge clk);
        flush = 0;
        #2 rst_n = 1'b0;
        #1 reset_vals("kr");
        @(negedge clk);
        ws = 0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rr_addr0", bus.addr, 32'h0);
        chk("rr_req", 32'(bus.req), 1);
        @(negedge clk);
        chk("rr_addr4", bus.addr, 32'h4);
        chk("rr_ifid_pc0", ifid_pc, 32'h0);
        chk("rr_ifid_v", 32'(ifid_v), 1);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
